// File: rtl/calc_pkg.sv
// Shared calculator definitions: key code width, ASCII key codes and issue-state encoding.
package calc_pkg;

  localparam int CHAR_W = 8;

  localparam logic [CHAR_W-1:0] KEY_0   = 8'h30;
  localparam logic [CHAR_W-1:0] KEY_1   = 8'h31;
  localparam logic [CHAR_W-1:0] KEY_2   = 8'h32;
  localparam logic [CHAR_W-1:0] KEY_3   = 8'h33;
  localparam logic [CHAR_W-1:0] KEY_4   = 8'h34;
  localparam logic [CHAR_W-1:0] KEY_5   = 8'h35;
  localparam logic [CHAR_W-1:0] KEY_6   = 8'h36;
  localparam logic [CHAR_W-1:0] KEY_7   = 8'h37;
  localparam logic [CHAR_W-1:0] KEY_8   = 8'h38;
  localparam logic [CHAR_W-1:0] KEY_9   = 8'h39;
  localparam logic [CHAR_W-1:0] KEY_ADD = 8'h2B;
  localparam logic [CHAR_W-1:0] KEY_SUB = 8'h2D;
  localparam logic [CHAR_W-1:0] KEY_MUL = 8'h2A;
  localparam logic [CHAR_W-1:0] KEY_DIV = 8'h2F;
  localparam logic [CHAR_W-1:0] KEY_EQ  = 8'h3D;
  localparam logic [CHAR_W-1:0] KEY_CLR = 8'h43;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/key_fifo.sv
// Synchronous key queue, power-of-2 depth; head is combinational, level updates one cycle after push/pop.
// Push while full and pop while empty are ignored; clear wins over push and pop.
module key_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int CHAR_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [CHAR_W-1:0]            din,
  output logic [CHAR_W-1:0]            dout,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [CHAR_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_event_sched.sv
// Round-robin merge of two key sources into one paced calc_fsm key strobe; accept-to-issue 2 cycles when idle.
// Sources see ready=0 when the queue is full or on tie loss; unheld offers that miss are flagged in overflow.
module key_event_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16,
  parameter int CHAR_W     = calc_pkg::CHAR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_valid,
  input  logic [CHAR_W-1:0]            a_char,
  output logic                         a_ready,
  input  logic                         b_valid,
  input  logic [CHAR_W-1:0]            b_char,
  output logic                         b_ready,
  input  logic                         flush,
  input  logic                         calc_busy,
  output logic                         key_valid,
  output logic [CHAR_W-1:0]            key_char,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow
);

  import calc_pkg::*;

  localparam int CW = $clog2(GAP_CYCLES);

  logic              full;
  logic              empty;
  logic [CHAR_W-1:0] head;
  logic              grant_a;
  logic              grant_b;
  logic              push;
  logic [CHAR_W-1:0] push_char;
  logic              rr_last_b;
  logic              a_lost;
  logic              b_lost;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;

  // A tie goes to whichever source did not win last.
  always_comb begin
    grant_a = a_valid && (!b_valid || rr_last_b);
    grant_b = b_valid && (!a_valid || !rr_last_b);
  end

  assign a_ready   = grant_a && !full;
  assign b_ready   = grant_b && !full;
  assign push      = a_ready || b_ready;
  assign push_char = a_ready ? a_char : b_char;

  key_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CHAR_W     (CHAR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (key_valid),
    .clear (flush),
    .din   (push_char),
    .dout  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_char  <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty && !calc_busy) begin
            state     <= ST_ISSUE;
            key_valid <= 1'b1;
            key_char  <= head;
          end
        end
        ST_ISSUE: begin
          state     <= ST_GAP;
          key_valid <= 1'b0;
          cnt       <= CW'(GAP_CYCLES - 1);
        end
        // calc_busy is deliberately not looked at here: the gap covers its rise latency.
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          key_valid <= 1'b0;
        end
      endcase
    end
  end

  // A tie loser that drops valid the next cycle has lost its key.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_b <= 1'b1;
      a_lost    <= 1'b0;
      b_lost    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (a_ready)      rr_last_b <= 1'b0;
      else if (b_ready) rr_last_b <= 1'b1;
      a_lost <= a_valid && !a_ready && !full && !flush;
      b_lost <= b_valid && !b_ready && !full && !flush;
      if (!flush && (((a_valid || b_valid) && full) ||
                     (a_lost && !a_valid) || (b_lost && !b_valid)))
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_event_sched.sv
// Randomized and directed bench for key_event_sched against a queue-based reference model.
module tb_key_event_sched;
  import calc_pkg::*;

  localparam int D   = 4;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst, a_valid, b_valid, flush, calc_busy;
  logic [7:0] a_char, b_char;
  logic       a_ready, b_ready, key_valid, overflow;
  logic [7:0] key_char;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  key_event_sched #(.FIFO_DEPTH(D), .GAP_CYCLES(GAP), .CHAR_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_char(a_char), .a_ready(a_ready),
    .b_valid(b_valid), .b_char(b_char), .b_ready(b_ready),
    .flush(flush), .calc_busy(calc_busy),
    .key_valid(key_valid), .key_char(key_char),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: queue contents, pending issue, time of last issue, fairness and loss flags.
  logic [7:0] mq[$];
  bit         m_pend;
  logic [7:0] m_pchar;
  bit         m_rr_b;
  bit         m_ovf;
  int         m_last;
  bit         m_alost, m_blost;

  int         iss_cyc[$];
  logic [7:0] iss_chr[$];
  bit         seen_a_rdy, seen_b_rdy;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend  = 0;
    m_pchar = '0;
    m_rr_b  = 1;
    m_ovf   = 0;
    m_last  = -1000;
    m_alost = 0;
    m_blost = 0;
  endtask

  task automatic tick();
    bit full, ga, gb, era, erb, issue_now, next_pend, ovf_set;
    logic [7:0] nchar;
    @(negedge clk);
    full = (mq.size() == D);
    ga   = a_valid && (!b_valid || m_rr_b);
    gb   = b_valid && (!a_valid || !m_rr_b);
    era  = ga && !full;
    erb  = gb && !full;
    check("a_ready", a_ready, era);
    check("b_ready", b_ready, erb);
    check("key_valid", key_valid, m_pend);
    if (m_pend) check("key_char", key_char, m_pchar);
    check("fifo_level", fifo_level, mq.size());
    check("overflow", overflow, m_ovf);
    if (key_valid === 1'b1) begin
      iss_cyc.push_back(cyc);
      iss_chr.push_back(key_char);
    end
    seen_a_rdy = a_ready;
    seen_b_rdy = b_ready;
    if (rst) begin
      model_reset();
    end else begin
      issue_now = m_pend;
      nchar     = (mq.size() > 0) ? mq[0] : 8'h00;
      next_pend = !issue_now && mq.size() > 0 && !calc_busy && !flush && (cyc >= m_last + GAP + 1);
      ovf_set   = !flush && ((a_valid && full) || (b_valid && full) ||
                             (m_alost && !a_valid) || (m_blost && !b_valid));
      m_alost   = a_valid && !era && !full && !flush;
      m_blost   = b_valid && !erb && !full && !flush;
      if (flush) begin
        mq.delete();
        m_pend = 0;
        m_last = -1000;
      end else begin
        if (issue_now) begin
          void'(mq.pop_front());
          m_last = cyc;
        end
        if (era)      mq.push_back(a_char);
        else if (erb) mq.push_back(b_char);
        m_pend = next_pend;
        if (next_pend) m_pchar = nchar;
      end
      if (era)      m_rr_b = 0;
      else if (erb) m_rr_b = 1;
      if (ovf_set) m_ovf = 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; flush = 0; rst = 0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    calc_busy = 0;
    rst = 1;
    tick();
    rst = 0;
    iss_cyc.delete();
    iss_chr.delete();
  endtask

  // Hold each requested source valid until it is accepted, with a cycle bound.
  task automatic offer2(input bit da, input logic [7:0] ca, input bit db, input logic [7:0] cb);
    int n;
    bit pa, pb;
    n = 0; pa = da; pb = db;
    while ((pa || pb) && n < 200) begin
      a_valid = pa; a_char = ca;
      b_valid = pb; b_char = cb;
      tick();
      if (pa && seen_a_rdy) pa = 0;
      if (pb && seen_b_rdy) pb = 0;
      n++;
    end
    a_valid = 0; b_valid = 0;
    if (pa || pb) check("offer_timeout", 1, 0);
  endtask

  initial begin
    int n0, f;
    bit ha, hb;
    logic [7:0] keys [5];
    keys[0] = KEY_2; keys[1] = KEY_3; keys[2] = KEY_MUL; keys[3] = KEY_9; keys[4] = KEY_EQ;
    a_char = '0; b_char = '0; calc_busy = 0;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check("rst_key_valid", key_valid, 0);
    check("rst_key_char", key_char, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);

    // Single key latency
    do_reset();
    n0 = cyc;
    offer2(1, KEY_5, 0, 8'h00);
    run(30);
    check("t1_count", iss_cyc.size(), 1);
    if (iss_cyc.size() >= 1) begin
      check("t1_latency", iss_cyc[0] - n0, 2);
      check("t1_char", iss_chr[0], 8'h35);
    end
    check("t1_level", fifo_level, 0);

    // Tie with both sources held
    do_reset();
    offer2(1, KEY_1, 1, KEY_ADD);
    run(60);
    check("t2_count", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 2) begin
      check("t2_first", iss_chr[0], KEY_1);
      check("t2_second", iss_chr[1], KEY_ADD);
      check("t2_spacing", iss_cyc[1] - iss_cyc[0], GAP + 2);
    end

    // Busy hold
    do_reset();
    calc_busy = 1;
    offer2(1, KEY_4, 0, 8'h00);
    offer2(1, KEY_SUB, 0, 8'h00);
    offer2(1, KEY_6, 0, 8'h00);
    run(97);
    check("t3_none_busy", iss_cyc.size(), 0);
    calc_busy = 0;
    f = cyc;
    run(80);
    check("t3_count", iss_cyc.size(), 3);
    if (iss_cyc.size() >= 3) begin
      check("t3_first_cyc", iss_cyc[0] - f, 1);
      check("t3_spacing", iss_cyc[2] - iss_cyc[1], GAP + 2);
      check("t3_order", iss_chr[2], KEY_6);
    end

    // Full and overflow
    do_reset();
    calc_busy = 1;
    for (int i = 0; i < 5; i++) begin
      a_valid = 1; a_char = keys[i];
      tick();
      check("t4_ready", seen_a_rdy, (i < 4));
    end
    a_valid = 0;
    tick();
    check("t4_overflow", overflow, 1);
    check("t4_level", fifo_level, 4);
    calc_busy = 0;
    run(100);
    check("t4_count", iss_cyc.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < iss_chr.size()) check("t4_order", iss_chr[i], keys[i]);

    // Flush during the gap
    do_reset();
    offer2(1, KEY_7, 0, 8'h00);
    offer2(1, KEY_8, 0, 8'h00);
    offer2(1, KEY_DIV, 0, 8'h00);
    run(2);
    check("t5_level_pre", fifo_level, 2);
    flush = 1; a_valid = 1; a_char = KEY_CLR;
    tick();
    flush = 0; a_valid = 0;
    check("t5_level", fifo_level, 0);
    run(60);
    check("t5_count", iss_cyc.size(), 1);
    check("t5_overflow", overflow, 0);

    // Reset in the ISSUE cycle
    do_reset();
    offer2(1, KEY_0, 0, 8'h00);
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("t6_issued", iss_cyc.size(), 1);
    check("t6_key_valid", key_valid, 0);
    check("t6_level", fifo_level, 0);
    iss_cyc.delete(); iss_chr.delete();
    offer2(1, KEY_7, 1, KEY_8);
    run(60);
    check("t6_count", iss_cyc.size(), 2);
    if (iss_chr.size() >= 1) check("t6_tie_a", iss_chr[0], KEY_7);

    // Randomized traffic
    do_reset();
    ha = 0; hb = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!ha) begin a_valid = ($urandom_range(3) == 0); a_char = 8'($urandom); end
      if (!hb) begin b_valid = ($urandom_range(3) == 0); b_char = 8'($urandom); end
      calc_busy = ($urandom_range(3) == 0);
      flush     = ($urandom_range(63) == 0);
      rst       = ($urandom_range(499) == 0);
      tick();
      ha = a_valid && !seen_a_rdy && ($urandom_range(7) != 0);
      hb = b_valid && !seen_b_rdy && ($urandom_range(7) != 0);
    end
    idle_inputs();
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
